// File: rtl/ddr2_data_tap_ctrl.sv
// ---------------------------------------------------------------------------
// ddr2_data_tap_ctrl
//
// Per-bit DQ input-delay calibration FSM. For the currently selected DQ
// channel it sweeps the IDELAY tap upward from 0, classifies the returned
// dq bit at every tap, finds the stable window of the value opposite to the
// tap-0 reference, and parks the tap at the window centre. It then pulses
// o_chan_done so the downstream stage advances to the next channel. This
// repeats until the downstream stage raises i_calib_done.
//
// Ports:
//   i_clk              system clock, rising edge
//   i_reset_n          synchronous active-low reset
//   i_calib_start      start level from controller init (sampled in IDLE only)
//   i_dq_data          muxed DQ bit of the selected channel
//   i_calib_done       downstream flag: all channels calibrated
//   o_dlyce            IDELAY clock enable, 1-cycle pulses
//   o_dlyinc           IDELAY direction (1 = inc), valid with o_dlyce
//   o_ctrl_calib_start high from leaving IDLE until DONE
//   o_chan_done        1-cycle pulse: current channel centred
//   o_tap_calib_done   high in DONE
//   o_center_tap       last computed centre tap
//   o_no_window        sticky: some channel had no stable flipped window
// ---------------------------------------------------------------------------
module ddr2_data_tap_ctrl #(
  parameter int unsigned TAP_W         = 6,
  parameter int unsigned MAX_TAP       = 63,
  parameter int unsigned SETTLE_CYCLES = 7,
  parameter int unsigned SAMPLE_CNT    = 4,
  parameter int unsigned CHAN_GAP      = 3
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_calib_start,
  input  logic             i_dq_data,
  input  logic             i_calib_done,
  output logic             o_dlyce,
  output logic             o_dlyinc,
  output logic             o_ctrl_calib_start,
  output logic             o_chan_done,
  output logic             o_tap_calib_done,
  output logic [TAP_W-1:0] o_center_tap,
  output logic             o_no_window
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + SAMPLE_CNT + CHAN_GAP + 1);

  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]  SampleLast = CntW'(SAMPLE_CNT - 1);
  localparam logic [CntW-1:0]  GapLast    = CntW'(CHAN_GAP - 1);
  localparam logic [TAP_W-1:0] MaxTap     = TAP_W'(MAX_TAP);
  localparam logic [TAP_W:0]   E1NoFlip   = (TAP_W + 1)'(MAX_TAP + 1);

  typedef enum logic [3:0] {
    StIdle,
    StSettle,
    StSample,
    StInc,
    StEor,
    StCenter,
    StDec,
    StChan,
    StGap,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    PhRef,
    PhSeekE1,
    PhSeekLo,
    PhSeekHi
  } phase_e;

  state_e           r_state, r_state_d;
  phase_e           r_phase;
  logic [CntW-1:0]  r_cnt;
  logic [TAP_W-1:0] r_tap_cnt;
  logic [TAP_W:0]   r_e1;
  logic [TAP_W-1:0] r_lo;
  logic [TAP_W-1:0] r_hi;
  logic [TAP_W-1:0] r_center;
  logic             r_ref;
  logic             r_all1;
  logic             r_all0;
  logic             r_dec_gap;
  logic             r_no_window;

  // Sample classification including the sample arriving this cycle.
  logic w_last_sample;
  logic w_stab1;
  logic w_stab0;
  logic w_stable;
  logic w_is_ref;
  logic w_is_nref;
  logic w_to_center;
  logic w_at_max;
  logic w_dec_pulse;

  logic [TAP_W:0]   w_sum;
  logic [TAP_W:0]   w_e1_m1;
  logic [TAP_W-1:0] w_center;

  always_comb begin
    w_last_sample = (r_state == StSample) && (r_cnt == SampleLast);
    w_stab1       = r_all1 & i_dq_data;
    w_stab0       = r_all0 & ~i_dq_data;
    w_stable      = w_stab1 | w_stab0;
    w_is_ref      = r_ref ? w_stab1 : w_stab0;
    w_is_nref     = r_ref ? w_stab0 : w_stab1;
    w_to_center   = (r_phase == PhSeekHi) && !w_is_nref;
    w_at_max      = (r_tap_cnt == MaxTap);
    w_dec_pulse   = (r_state == StDec) && !r_dec_gap && (r_tap_cnt > r_center);
  end

  // Centre computed at TAP_W+1 bits; the shift is the [TAP_W:1] slice.
  always_comb begin
    w_sum   = {1'b0, r_lo} + {1'b0, r_hi};
    w_e1_m1 = r_e1 - (TAP_W + 1)'(1);
    if (r_phase == PhSeekHi) begin
      w_center = w_sum[TAP_W:1];
    end else if (r_e1 == '0) begin
      w_center = '0;
    end else begin
      w_center = w_e1_m1[TAP_W:1];
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= r_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    r_state_d = r_state;
    unique case (r_state)
      StIdle:   if (i_calib_start) r_state_d = StSettle;
      StSettle: if (r_cnt == SettleLast) r_state_d = StSample;
      StSample: begin
        if (w_last_sample) begin
          if (w_to_center) begin
            r_state_d = StCenter;
          end else if (w_at_max) begin
            r_state_d = StEor;
          end else begin
            r_state_d = StInc;
          end
        end
      end
      StInc:    r_state_d = StSettle;
      StEor:    r_state_d = StCenter;
      StCenter: r_state_d = StDec;
      StDec:    if (!r_dec_gap && (r_tap_cnt <= r_center)) r_state_d = StChan;
      StChan:   r_state_d = StGap;
      StGap: begin
        if (r_cnt == GapLast) r_state_d = i_calib_done ? StDone : StSettle;
      end
      StDone:   r_state_d = StDone;
      default:  r_state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_dlyce            = (r_state == StInc) || w_dec_pulse;
    o_dlyinc           = (r_state == StInc);
    o_ctrl_calib_start = (r_state != StIdle) && (r_state != StDone);
    o_chan_done        = (r_state == StChan);
    o_tap_calib_done   = (r_state == StDone);
    o_center_tap       = r_center;
    o_no_window        = r_no_window;
  end

  // Datapath: tap counter, sample accumulation, window edges
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_phase     <= PhRef;
      r_cnt       <= '0;
      r_tap_cnt   <= '0;
      r_e1        <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_center    <= '0;
      r_ref       <= 1'b0;
      r_all1      <= 1'b0;
      r_all0      <= 1'b0;
      r_dec_gap   <= 1'b0;
      r_no_window <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_calib_start) begin
            r_tap_cnt <= '0;
            r_cnt     <= '0;
            r_phase   <= PhRef;
          end
        end
        StSettle: begin
          if (r_cnt == SettleLast) begin
            r_cnt  <= '0;
            r_all1 <= 1'b1;
            r_all0 <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StSample: begin
          r_all1 <= w_stab1;
          r_all0 <= w_stab0;
          if (w_last_sample) begin
            r_cnt <= '0;
            unique case (r_phase)
              PhRef: begin
                if (w_stable) begin
                  r_ref   <= w_stab1;
                  r_phase <= PhSeekE1;
                end else begin
                  r_e1    <= '0;
                  r_phase <= PhSeekLo;
                end
              end
              PhSeekE1: begin
                // Leaving the reference value: the same sample may already
                // be the first stable flipped one.
                if (!w_is_ref) begin
                  r_e1 <= {1'b0, r_tap_cnt};
                  if (w_is_nref) begin
                    r_lo    <= r_tap_cnt;
                    r_phase <= PhSeekHi;
                  end else begin
                    r_phase <= PhSeekLo;
                  end
                end
              end
              PhSeekLo: begin
                if (w_is_nref) begin
                  r_lo    <= r_tap_cnt;
                  r_phase <= PhSeekHi;
                end
              end
              PhSeekHi: begin
                if (!w_is_nref) r_hi <= r_tap_cnt - TAP_W'(1);
              end
              default: ;
            endcase
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StInc: begin
          r_tap_cnt <= r_tap_cnt + TAP_W'(1);
          r_cnt     <= '0;
        end
        StEor: begin
          unique case (r_phase)
            PhSeekHi: r_hi <= MaxTap;
            PhSeekLo: r_no_window <= 1'b1;
            PhSeekE1: begin
              r_no_window <= 1'b1;
              r_e1        <= E1NoFlip;
            end
            default: ;
          endcase
        end
        StCenter: r_center <= w_center;
        StDec: begin
          // One idle cycle after every decrement keeps dlyce pulses apart.
          if (r_dec_gap) begin
            r_dec_gap <= 1'b0;
          end else if (r_tap_cnt > r_center) begin
            r_tap_cnt <= r_tap_cnt - TAP_W'(1);
            r_dec_gap <= 1'b1;
          end
        end
        StChan: begin
          r_tap_cnt <= '0;
          r_phase   <= PhRef;
          r_lo      <= '0;
          r_hi      <= '0;
          r_cnt     <= '0;
          r_dec_gap <= 1'b0;
        end
        StGap: begin
          if (r_cnt == GapLast) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_data_tap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddr2_data_tap_ctrl
//
// Directed bench. A behavioural IDELAY + data-eye model tracks the tap from
// dlyce/dlyinc pulses and returns dq_data for the modelled channel.
// Modes: 0 window (0 / toggle / 1 / 0), 1 constant 0, 2 flips at tap 20,
// 3 toggling at every tap.
// ---------------------------------------------------------------------------
module tb_ddr2_data_tap_ctrl;

  localparam int unsigned TapW   = 6;
  localparam int          Budget = 2000;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            calib_start;
  logic            dq_data = 1'b0;
  logic            calib_done;
  logic            dlyce;
  logic            dlyinc;
  logic            ctrl_calib_start;
  logic            chan_done;
  logic            tap_calib_done;
  logic [TapW-1:0] center_tap;
  logic            no_window;

  always #5 clk = ~clk;

  ddr2_data_tap_ctrl #(
    .TAP_W        (TapW),
    .MAX_TAP      (63),
    .SETTLE_CYCLES(7),
    .SAMPLE_CNT   (4),
    .CHAN_GAP     (3)
  ) dut (
    .i_clk             (clk),
    .i_reset_n         (reset_n),
    .i_calib_start     (calib_start),
    .i_dq_data         (dq_data),
    .i_calib_done      (calib_done),
    .o_dlyce           (dlyce),
    .o_dlyinc          (dlyinc),
    .o_ctrl_calib_start(ctrl_calib_start),
    .o_chan_done       (chan_done),
    .o_tap_calib_done  (tap_calib_done),
    .o_center_tap      (center_tap),
    .o_no_window       (no_window)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mode     = 0;
  int   m_tap    = 0;
  logic tgl      = 1'b0;
  int   inc_cnt  = 0;
  int   dec_cnt  = 0;
  int   chan_cnt = 0;
  int   adj_err  = 0;
  logic prev_dlyce = 1'b0;

  function automatic logic model_dq(input int md, input int tap, input logic t);
    case (md)
      0:       model_dq = (tap < 10) ? 1'b0 : (tap < 12) ? t : (tap <= 30) ? 1'b1 : 1'b0;
      1:       model_dq = 1'b0;
      2:       model_dq = (tap >= 20);
      default: model_dq = t;
    endcase
  endfunction

  // IDELAY model and pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_tap      = 0;
      inc_cnt    = 0;
      dec_cnt    = 0;
      chan_cnt   = 0;
      adj_err    = 0;
      prev_dlyce = 1'b0;
    end else begin
      if (dlyce && prev_dlyce) adj_err++;
      if (dlyce && chan_done) adj_err++;
      if (dlyce) begin
        if (dlyinc) begin
          inc_cnt++;
          m_tap++;
        end else begin
          dec_cnt++;
          m_tap--;
        end
      end
      if (chan_done) begin
        chan_cnt++;
        m_tap = 0;
      end
      prev_dlyce = dlyce;
    end
    tgl     = ~tgl;
    dq_data = model_dq(mode, m_tap, tgl);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    calib_start = 1'b0;
    calib_done  = 1'b0;
    reset_n     = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_chan(input int target);
    int n;
    n = 0;
    while (chan_cnt < target && n < Budget * target) begin
      tick();
      n++;
    end
  endtask

  // Single-channel sweep with calib_done already high: ends in DONE.
  task automatic run_single(input string tag, input int md, input int exp_center,
                            input int exp_nowin, input int exp_inc, input int exp_dec);
    do_reset();
    mode        = md;
    calib_done  = 1'b1;
    calib_start = 1'b1;
    wait_chan(1);
    check_eq({tag, "_chan"}, chan_cnt, 1);
    check_eq({tag, "_center"}, int'(center_tap), exp_center);
    check_eq({tag, "_nowin"}, int'(no_window), exp_nowin);
    check_eq({tag, "_inc"}, inc_cnt, exp_inc);
    check_eq({tag, "_dec"}, dec_cnt, exp_dec);
    check_eq({tag, "_tap"}, m_tap, 0);
    repeat (4) tick();
    check_eq({tag, "_done"}, int'(tap_calib_done), 1);
    check_eq({tag, "_ctrl"}, int'(ctrl_calib_start), 0);
    check_eq({tag, "_adj"}, adj_err, 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    calib_start = 1'b0;
    calib_done  = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_dlyce", int'(dlyce), 0);
    check_eq("rst_ctrl", int'(ctrl_calib_start), 0);
    check_eq("rst_chan", int'(chan_done), 0);
    check_eq("rst_done", int'(tap_calib_done), 0);
    check_eq("rst_center", int'(center_tap), 0);
    check_eq("rst_nowin", int'(no_window), 0);
    tick();
    check_eq("idle_ctrl", int'(ctrl_calib_start), 0);

    run_single("win", 0, 21, 0, 31, 10);
    run_single("zero", 1, 31, 1, 63, 32);
    run_single("flip20", 2, 41, 0, 63, 22);
    run_single("unstable", 3, 0, 1, 63, 63);

    // Eight channels, calib_done raised after the 8th chan_done.
    do_reset();
    mode        = 0;
    calib_start = 1'b1;
    wait_chan(8);
    calib_done = 1'b1;
    check_eq("multi_chan", chan_cnt, 8);
    check_eq("multi_center", int'(center_tap), 21);
    check_eq("multi_inc", inc_cnt, 8 * 31);
    check_eq("multi_dec", dec_cnt, 8 * 10);
    repeat (4) tick();
    check_eq("multi_done", int'(tap_calib_done), 1);
    check_eq("multi_ctrl", int'(ctrl_calib_start), 0);
    repeat (20) tick();
    check_eq("multi_chan_hold", chan_cnt, 8);
    check_eq("multi_adj", adj_err, 0);

    // Reset mid SEEK_HI at tap 25, calib_start held high.
    do_reset();
    mode        = 0;
    calib_start = 1'b1;
    begin
      int n;
      n = 0;
      while (m_tap != 25 && n < Budget) begin
        tick();
        n++;
      end
    end
    check_eq("mid_tap25", m_tap, 25);
    reset_n = 1'b0;
    tick();
    check_eq("mid_rst_dlyce", int'(dlyce), 0);
    check_eq("mid_rst_ctrl", int'(ctrl_calib_start), 0);
    check_eq("mid_rst_chan", int'(chan_done), 0);
    check_eq("mid_rst_done", int'(tap_calib_done), 0);
    check_eq("mid_rst_center", int'(center_tap), 0);
    reset_n = 1'b1;
    tick();
    check_eq("mid_restart_ctrl", int'(ctrl_calib_start), 1);
    wait_chan(1);
    check_eq("mid_center", int'(center_tap), 21);
    check_eq("mid_inc", inc_cnt, 31);
    check_eq("mid_dec", dec_cnt, 10);
    check_eq("mid_adj", adj_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
